usb_tx_seq: RTL and testbench

Transmit sequencer that drives the bit stuffer on the USB-style serial transmit path. It takes bytes from the packet buffer over a valid/ready handshake and emits a SYNC pattern followed by the packet bytes, LSB first, one bit per cycle on the stuffer's input. It honours the stuffer's `pause` by holding the current bit, absorbs any trailing stuffed bit, and then signals end-of-packet to the downstream NRZI/line driver.

---
 rtl/usb_tx_seq.sv | 124 ++++++++++++
 tb/tb_usb_tx_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_seq.sv
// Transmit sequencer feeding the bit stuffer: SYNC, then packet bytes LSB first,
// a tail cycle for a trailing stuffed bit, then a fixed-length end-of-packet.
module usb_tx_seq #(
    parameter logic [7:0] SYNC_PAT = 8'h80,
    parameter int         EOP_LEN  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       pause,
    output logic       bit_out,
    output logic       eop,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = (EOP_LEN < 2) ? 1 : $clog2(EOP_LEN + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        TAIL = 3'd3,
        EOP  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [7:0]       sr, sr_n;
    logic [2:0]       idx, idx_n;
    logic             last_q, last_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= 8'd0;
            idx    <= 3'd0;
            last_q <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            idx    <= idx_n;
            last_q <= last_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        sr_n       = sr;
        idx_n      = idx;
        last_n     = last_q;
        cnt_n      = cnt;
        byte_ready = 1'b0;
        bit_out    = 1'b0;
        eop        = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    sr_n    = SYNC_PAT;
                    idx_n   = 3'd0;
                    last_n  = 1'b0;
                    state_n = SYNC;
                end
            end

            SYNC, DATA: begin
                bit_out = sr[0];
                // A paused cycle is swallowed by the stuffer, so the current bit is held
                if (!pause) begin
                    sr_n  = {1'b0, sr[7:1]};
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
                        if (state == DATA && last_q) begin
                            state_n = TAIL;
                        end else begin
                            byte_ready = 1'b1;
                            if (byte_valid) begin
                                sr_n    = byte_in;
                                last_n  = byte_last;
                                state_n = DATA;
                            end else begin
                                err     = 1'b1;
                                state_n = TAIL;
                            end
                        end
                    end
                end
            end

            TAIL: begin
                if (!pause) begin
                    cnt_n   = CNT_W'(EOP_LEN - 1);
                    state_n = EOP;
                end
            end

            EOP: begin
                eop = 1'b1;
                if (cnt == '0) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_tx_seq.sv
// Directed bench for usb_tx_seq with a behavioural bit stuffer driving pause.
module tb_usb_tx_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       pause;
    logic       bit_out;
    logic       eop;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt [4];
    int         npkt = 0;
    int         ptr  = 0;
    logic       stuff_en = 1'b0;
    int         ones = 0;

    logic [31:0] v_bit, v_rdy, v_eop, v_done, v_err, v_pau;
    int          busy_len;

    always #5 clk = ~clk;

    usb_tx_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .pause      (pause),
        .bit_out    (bit_out),
        .eop        (eop),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Packet buffer model
    assign byte_valid = (ptr < npkt);
    assign byte_in    = (ptr < npkt) ? pkt[ptr[1:0]] : 8'h00;
    assign byte_last  = (ptr == npkt - 1);

    always @(posedge clk) begin
        if (start) ptr <= 0;
        else if (byte_ready && byte_valid) ptr <= ptr + 1;
    end

    // Bit stuffer model: after six consecutive ones it inserts a 0 (pause) for one cycle
    assign pause = stuff_en && (ones == 6);

    always @(posedge clk) begin
        if (!stuff_en || pause) ones <= 0;
        else if (bit_out) ones <= ones + 1;
        else ones <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start a packet and record per-cycle outputs; bit k-1 of each vector is cycle t+k
    task automatic run_pkt(input string tag);
        logic timed_out;
        timed_out = 1'b1;
        v_bit = '0; v_rdy = '0; v_eop = '0; v_done = '0; v_err = '0; v_pau = '0;
        busy_len = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            busy_len++;
            v_bit[k-1]  = bit_out;
            v_rdy[k-1]  = byte_ready;
            v_eop[k-1]  = eop;
            v_done[k-1] = done;
            v_err[k-1]  = err;
            v_pau[k-1]  = pause;
            @(posedge clk);
            #2;
        end
        check({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
    endtask

    initial begin
        int eop_seen;
        rst        = 1'b1;
        start      = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_bit",   {31'd0, bit_out},    32'd0);
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_eop",   {31'd0, eop},        32'd0);
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_done",  {31'd0, done | err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("idle_bit",  {31'd0, bit_out}, 32'd0);
        check("idle_busy", {31'd0, busy},    32'd0);

        // One byte A5, no pauses: SYNC then A5 LSB first, TAIL t+17, eop t+18..19
        pkt[0] = 8'hA5; npkt = 1; stuff_en = 1'b0;
        run_pkt("a5");
        check("a5_bits", v_bit,  32'h0000_A580);
        check("a5_rdy",  v_rdy,  32'h0000_0080);
        check("a5_eop",  v_eop,  32'h0006_0000);
        check("a5_done", v_done, 32'h0004_0000);
        check("a5_err",  v_err,  32'h0000_0000);
        check("a5_busy", busy_len, 32'd19);

        // FF,00 through the stuffer: SYNC's final 1 plus five data ones trigger a pause at t+14
        pkt[0] = 8'hFF; pkt[1] = 8'h00; npkt = 2; stuff_en = 1'b1;
        run_pkt("ff00");
        check("ff00_bits",  v_bit,  32'h0001_FF80);
        check("ff00_pause", v_pau,  32'h0000_2000);
        check("ff00_rdy",   v_rdy,  32'h0001_0080);
        check("ff00_eop",   v_eop,  32'h0C00_0000);
        check("ff00_done",  v_done, 32'h0800_0000);
        // 8 sync + 1 pause + 16 data + 1 tail + 2 eop
        check("ff00_busy",  busy_len, 32'd28);

        // Last byte FC ends in six ones: the stuffed 0 lands in TAIL, stretching it to 2 cycles
        pkt[0] = 8'hFC; npkt = 1; stuff_en = 1'b1;
        run_pkt("fc");
        check("fc_bits",  v_bit,  32'h0000_FC80);
        check("fc_pause", v_pau,  32'h0001_0000);
        check("fc_eop",   v_eop,  32'h000C_0000);
        check("fc_done",  v_done, 32'h0008_0000);
        check("fc_busy",  busy_len, 32'd20);

        // Underrun at the first byte boundary
        npkt = 0; stuff_en = 1'b0;
        run_pkt("urun");
        check("urun_err",  v_err,  32'h0000_0080);
        check("urun_rdy",  v_rdy,  32'h0000_0080);
        check("urun_bits", v_bit,  32'h0000_0080);
        check("urun_eop",  v_eop,  32'h0000_0600);
        check("urun_done", v_done, 32'h0000_0400);
        check("urun_overlap", v_err & v_done, 32'h0);
        check("urun_busy", busy_len, 32'd11);

        // Reset during the second data byte (cycle t+19)
        pkt[0] = 8'h11; pkt[1] = 8'h22; npkt = 2; stuff_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #3;
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_busy", {31'd0, busy},       32'd0);
        check("mid_bit",  {31'd0, bit_out},    32'd0);
        check("mid_eop",  {31'd0, eop},        32'd0);
        check("mid_rdy",  {31'd0, byte_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        eop_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            if (eop || busy) eop_seen++;
        end
        check("mid_no_eop", eop_seen, 32'd0);

        // Fresh packet after the reset must start with a clean SYNC
        pkt[0] = 8'hA5; npkt = 1; stuff_en = 1'b0;
        run_pkt("again");
        check("again_bits", v_bit,  32'h0000_A580);
        check("again_done", v_done, 32'h0004_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
